symbol_align: RTL and testbench
===============================

// Module: symbol_align
// PURPOSE
//  Consumes comma_align's offset/comma alongside the same raw 10b deserializer word.
//  Runs a lock FSM that confirms a stable comma offset, then barrel-shifts the raw
//  stream onto the 10b symbol boundary. Feeds the 8b/10b decoder.
//  Holds a lock through isolated misaligned/missing commas; drops it on persistent error.
// PARAMETERS
//  ACQUIRE_COUNT  3     consecutive commas at one offset needed to lock (>=1)
//  MISALIGN_COUNT 4     consecutive commas at a foreign offset that break lock (>=1)
//  TIMEOUT        4096  words without an in-lock comma before lock is dropped (>=20)
// PORTS
//  clk          in   1   clock
//  reset_n      in   1   asynchronous active-low reset
//  input_data   in   10  raw deserializer word, same cycle as comma_align input
//  offset       in   4   comma_align offset, valid when comma=1
//  comma        in   1   comma_align comma found this cycle
//  symbol_out   out  10  aligned symbol, registered
//  symbol_valid out  1   symbol_out is aligned data (state LOCKED)
//  symbol_k     out  1   symbol_out is K28.5 (0011111010 or 1100000101)
//  locked       out  1   FSM in LOCKED
//  lock_offset  out  4   offset in use while locked, 0 otherwise
//  lock_lost    out  1   one-cycle pulse on LOCKED->HUNT
// BEHAVIOUR
//  - Reset (async, reset_n=0): state HUNT; all outputs 0; internal last_word 9'b0;
//    all counters 0. Reset mid-lock takes effect immediately; no lock_lost pulse.
//  - Window: search_word = {last_word, input_data}; last_word <= input_data[8:0] per clk.
//    Bit layout identical to comma_align so offset indexes search_word[offset+:10].
//  - comma with offset>9 is treated as no comma.
//  - HUNT: comma -> cand<=offset, acq_cnt<=1, to CONFIRM (to LOCKED if ACQUIRE_COUNT==1).
//  - CONFIRM: comma&&offset==cand -> acq_cnt++; at ACQUIRE_COUNT -> LOCKED, lock_off<=cand.
//    comma&&offset!=cand -> cand<=offset, acq_cnt<=1, stay. Words since last comma
//    reaching TIMEOUT -> HUNT.
//  - LOCKED: comma&&offset==lock_off -> mis_cnt<=0, tmo_cnt<=0.
//    comma&&offset!=lock_off -> mis_cnt++; at MISALIGN_COUNT -> HUNT.
//    no comma -> tmo_cnt++ (mis_cnt held); at TIMEOUT -> HUNT.
//    Same-cycle mis and timeout thresholds: single HUNT transition, single lock_lost.
//  - On LOCKED->HUNT: lock_lost=1 for one cycle, symbol_valid/locked/lock_offset -> 0
//    same edge; counters cleared. A comma in that same cycle is not re-evaluated.
//  - Datapath (1-cycle latency): each edge symbol_out <= search_word[lock_off+:10],
//    symbol_k <= K28.5 match of that slice, symbol_valid <= (state==LOCKED before edge).
//    Acquisition edge: first valid symbol is the word after the completing comma.
//    symbol_out is don't-care (but deterministic) when symbol_valid=0.
//  - Counters saturate; no wrap. Widths $clog2(param+1).
// TESTING
//  - Reset: reset_n=0 mid-LOCKED -> all outputs 0 asynchronously, state HUNT.
//  - Acquire: K28.5 every 10 words at bit offset 3 -> locked after 3rd comma;
//    lock_offset=3; symbol_k=1 one cycle after each comma word; data symbols exact.
//  - Retarget: commas at offset 3,3,6,6,6 -> lock at 6 after 5th comma, never at 3.
//  - Misalign: locked at 3, then 4 commas at offset 7 -> lock_lost pulse on 4th,
//    relock at 7 after 3 more; 3 foreign commas then 1 at 3 -> lock held.
//  - Timeout: locked, no commas for 4096 words -> lock_lost exactly on 4096th word.
//  - Out-of-range: comma=1 with offset=12 in HUNT -> stays HUNT, no output change.

Source files
------------

// File: rtl/symbol_align.sv
// symbol_align: confirms a stable comma offset reported by comma_align, then
// barrel-shifts the raw 10b deserializer stream onto the symbol boundary.
// A lock survives isolated missing or misplaced commas and is dropped only
// after a run of foreign commas or a long stretch without an in-lock comma.
module symbol_align #(
    parameter int ACQUIRE_COUNT  = 3,
    parameter int MISALIGN_COUNT = 4,
    parameter int TIMEOUT        = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] input_data,
    input  logic [3:0] offset,
    input  logic       comma,
    output logic [9:0] symbol_out,
    output logic       symbol_valid,
    output logic       symbol_k,
    output logic       locked,
    output logic [3:0] lock_offset,
    output logic       lock_lost
);

    localparam int AW = $clog2(ACQUIRE_COUNT + 1);
    localparam int MW = $clog2(MISALIGN_COUNT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] ACQ_MAX  = AW'(ACQUIRE_COUNT);
    localparam logic [AW-1:0] ACQ_LAST = AW'(ACQUIRE_COUNT - 1);
    localparam logic [MW-1:0] MIS_MAX  = MW'(MISALIGN_COUNT);
    localparam logic [MW-1:0] MIS_LAST = MW'(MISALIGN_COUNT - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [9:0] K28_5_NEG = 10'b0011111010;
    localparam logic [9:0] K28_5_POS = 10'b1100000101;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      cand_reg, cand_next;
    logic [3:0]      lock_off_reg, lock_off_next;
    logic [AW-1:0]   acq_cnt_reg, acq_cnt_next;
    logic [MW-1:0]   mis_cnt_reg, mis_cnt_next;
    logic [TW-1:0]   tmo_cnt_reg, tmo_cnt_next;
    logic            lock_lost_next;
    logic [8:0]      last_word_reg;

    logic [18:0]     search_word;
    logic [9:0]      slices [10];
    logic [9:0]      slice_sel;
    logic            comma_ok;

    // Same window layout as comma_align, so offset indexes search_word directly.
    assign search_word = {last_word_reg, input_data};

    // An offset beyond the last legal slice position cannot be a real comma.
    assign comma_ok = comma && (offset <= 4'd9);

    assign locked      = (state_reg == LOCKED);
    assign lock_offset = lock_off_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_slice
            assign slices[gi] = search_word[gi +: 10];
        end
    endgenerate

    // Barrel-shift mux: pick the 10b slice at the locked offset.
    always_comb begin
        slice_sel = '0;
        for (int i = 0; i < 10; i++) begin
            if (lock_off_reg == 4'(i)) begin
                slice_sel = slices[i];
            end
        end
    end

    // Lock FSM next-state and counter logic.
    always_comb begin
        state_next     = state_reg;
        cand_next      = cand_reg;
        lock_off_next  = lock_off_reg;
        acq_cnt_next   = acq_cnt_reg;
        mis_cnt_next   = mis_cnt_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        lock_lost_next = 1'b0;

        case (state_reg)
            HUNT: begin
                if (comma_ok) begin
                    cand_next    = offset;
                    tmo_cnt_next = '0;
                    if (ACQUIRE_COUNT <= 1) begin
                        state_next    = LOCKED;
                        lock_off_next = offset;
                        acq_cnt_next  = '0;
                    end else begin
                        state_next   = CONFIRM;
                        acq_cnt_next = AW'(1);
                    end
                end
            end

            CONFIRM: begin
                if (comma_ok) begin
                    tmo_cnt_next = '0;
                    if (offset == cand_reg) begin
                        if (acq_cnt_reg >= ACQ_LAST) begin
                            state_next    = LOCKED;
                            lock_off_next = cand_reg;
                            acq_cnt_next  = '0;
                            mis_cnt_next  = '0;
                        end else begin
                            acq_cnt_next = (acq_cnt_reg == ACQ_MAX) ? acq_cnt_reg
                                                                    : acq_cnt_reg + 1'b1;
                        end
                    end else begin
                        // Restart confirmation at the newly seen offset.
                        cand_next    = offset;
                        acq_cnt_next = AW'(1);
                    end
                end else if (tmo_cnt_reg >= TMO_LAST) begin
                    state_next   = HUNT;
                    cand_next    = '0;
                    acq_cnt_next = '0;
                    tmo_cnt_next = '0;
                end else begin
                    tmo_cnt_next = (tmo_cnt_reg == TMO_MAX) ? tmo_cnt_reg
                                                            : tmo_cnt_reg + 1'b1;
                end
            end

            LOCKED: begin
                if (comma_ok && (offset == lock_off_reg)) begin
                    mis_cnt_next = '0;
                    tmo_cnt_next = '0;
                end else if ((comma_ok && (mis_cnt_reg >= MIS_LAST)) ||
                             (tmo_cnt_reg >= TMO_LAST)) begin
                    // Either threshold (or both at once) yields one drop.
                    state_next     = HUNT;
                    lock_lost_next = 1'b1;
                    lock_off_next  = '0;
                    cand_next      = '0;
                    acq_cnt_next   = '0;
                    mis_cnt_next   = '0;
                    tmo_cnt_next   = '0;
                end else begin
                    // A foreign comma is not an in-lock comma, so it also ages the timeout.
                    if (comma_ok) begin
                        mis_cnt_next = (mis_cnt_reg == MIS_MAX) ? mis_cnt_reg
                                                                : mis_cnt_reg + 1'b1;
                    end
                    tmo_cnt_next = (tmo_cnt_reg == TMO_MAX) ? tmo_cnt_reg
                                                            : tmo_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next    = HUNT;
                cand_next     = '0;
                lock_off_next = '0;
                acq_cnt_next  = '0;
                mis_cnt_next  = '0;
                tmo_cnt_next  = '0;
            end
        endcase
    end

    // FSM state, counters and lock bookkeeping registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= HUNT;
            cand_reg     <= '0;
            lock_off_reg <= '0;
            acq_cnt_reg  <= '0;
            mis_cnt_reg  <= '0;
            tmo_cnt_reg  <= '0;
            lock_lost    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cand_reg     <= cand_next;
            lock_off_reg <= lock_off_next;
            acq_cnt_reg  <= acq_cnt_next;
            mis_cnt_reg  <= mis_cnt_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            lock_lost    <= lock_lost_next;
        end
    end

    // Aligned symbol datapath; valid only while lock is held across the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_word_reg <= '0;
            symbol_out    <= '0;
            symbol_k      <= 1'b0;
            symbol_valid  <= 1'b0;
        end else begin
            last_word_reg <= input_data[8:0];
            symbol_out    <= slice_sel;
            symbol_k      <= (slice_sel == K28_5_NEG) || (slice_sel == K28_5_POS);
            symbol_valid  <= (state_reg == LOCKED) && (state_next == LOCKED);
        end
    end

endmodule

// File: tb/tb_symbol_align.sv
// Directed bench for symbol_align: acquisition, symbol extraction, misalign
// tolerance and drop, async reset, retargeting, timeout and bad offsets.
module tb_symbol_align;

    logic       clk;
    logic       reset_n;
    logic [9:0] input_data;
    logic [3:0] offset;
    logic       comma;
    logic [9:0] symbol_out;
    logic       symbol_valid;
    logic       symbol_k;
    logic       locked;
    logic [3:0] lock_offset;
    logic       lock_lost;

    int n_vec = 0;
    int n_err = 0;
    int ts    = 0;

    localparam logic [9:0] K28_5 = 10'b0011111010;

    symbol_align #(
        .ACQUIRE_COUNT (3),
        .MISALIGN_COUNT(4),
        .TIMEOUT       (4096)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .input_data  (input_data),
        .offset      (offset),
        .comma       (comma),
        .symbol_out  (symbol_out),
        .symbol_valid(symbol_valid),
        .symbol_k    (symbol_k),
        .locked      (locked),
        .lock_offset (lock_offset),
        .lock_lost   (lock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Intended symbol stream: a K28.5 every 10 words, otherwise non-K data.
    function automatic logic [9:0] sym_at(input int t);
        logic [9:0] d;
        d = 10'h2A0 | 10'(t & 31);
        return (t % 10 == 0) ? K28_5 : d;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serialize symbols so that search_word[off+:10] holds sym_at(ts) this cycle.
    task automatic tick(input int off);
        logic [19:0] pair;
        pair       = {sym_at(ts), sym_at(ts + 1)};
        input_data = 10'(pair >> (10 - off));
        comma      = (ts % 10 == 0);
        offset     = 4'(off);
        @(posedge clk);
        #1;
        ts++;
    endtask

    // Drive an arbitrary data word with explicit comma/offset.
    task automatic raw(input logic c, input logic [3:0] o);
        input_data = 10'h2B5;
        comma      = c;
        offset     = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        input_data = '0;
        offset     = '0;
        comma      = 1'b0;
        #12;
        check("rst_locked", 16'(locked), 16'h0);
        check("rst_valid", 16'(symbol_valid), 16'h0);
        check("rst_sym", 16'(symbol_out), 16'h0);
        check("rst_lost", 16'(lock_lost), 16'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Acquire at offset 3: commas at ts 0, 10, 20.
        ts = 0;
        repeat (20) tick(3);
        check("acq_pre_locked", 16'(locked), 16'h0);
        tick(3);
        check("acq_locked", 16'(locked), 16'h1);
        check("acq_offset", 16'(lock_offset), 16'h3);
        check("acq_valid_first", 16'(symbol_valid), 16'h0);
        tick(3);
        check("acq_valid", 16'(symbol_valid), 16'h1);
        check("acq_sym21", 16'(symbol_out), 16'(sym_at(21)));
        check("acq_k21", 16'(symbol_k), 16'h0);
        repeat (9) begin
            tick(3);
            check("data_sym", 16'(symbol_out), 16'(sym_at(ts - 1)));
        end
        check("comma_sym", 16'(symbol_out), 16'(K28_5));
        check("comma_k", 16'(symbol_k), 16'h1);

        // Misalign: 3 foreign commas then an in-lock comma keeps the lock.
        repeat (3) raw(1'b1, 4'd7);
        check("mis3_locked", 16'(locked), 16'h1);
        raw(1'b1, 4'd3);
        check("mis_reset_locked", 16'(locked), 16'h1);
        repeat (3) raw(1'b1, 4'd7);
        check("mis3b_locked", 16'(locked), 16'h1);
        check("mis3b_lost", 16'(lock_lost), 16'h0);
        raw(1'b1, 4'd7);
        check("mis4_lost", 16'(lock_lost), 16'h1);
        check("mis4_locked", 16'(locked), 16'h0);
        check("mis4_offset", 16'(lock_offset), 16'h0);
        check("mis4_valid", 16'(symbol_valid), 16'h0);
        raw(1'b0, 4'd0);
        check("mis_lost_pulse", 16'(lock_lost), 16'h0);
        repeat (2) raw(1'b1, 4'd7);
        check("relock2_locked", 16'(locked), 16'h0);
        raw(1'b1, 4'd7);
        check("relock_locked", 16'(locked), 16'h1);
        check("relock_offset", 16'(lock_offset), 16'h7);

        // Asynchronous reset in the middle of a cycle while locked.
        raw(1'b0, 4'd0);
        check("prereset_valid", 16'(symbol_valid), 16'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_locked", 16'(locked), 16'h0);
        check("arst_offset", 16'(lock_offset), 16'h0);
        check("arst_valid", 16'(symbol_valid), 16'h0);
        check("arst_lost", 16'(lock_lost), 16'h0);
        check("arst_sym", 16'(symbol_out), 16'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Retarget: 3,3,6,6,6 locks at 6 on the fifth comma.
        raw(1'b1, 4'd3);
        raw(1'b0, 4'd0);
        raw(1'b1, 4'd3);
        check("ret_33_locked", 16'(locked), 16'h0);
        raw(1'b1, 4'd6);
        raw(1'b1, 4'd6);
        check("ret_4th_locked", 16'(locked), 16'h0);
        raw(1'b1, 4'd6);
        check("ret_locked", 16'(locked), 16'h1);
        check("ret_offset", 16'(lock_offset), 16'h6);

        // Timeout: drop exactly on the 4096th comma-free word.
        repeat (4095) raw(1'b0, 4'd0);
        check("tmo_4095_locked", 16'(locked), 16'h1);
        check("tmo_4095_lost", 16'(lock_lost), 16'h0);
        raw(1'b0, 4'd0);
        check("tmo_lost", 16'(lock_lost), 16'h1);
        check("tmo_locked", 16'(locked), 16'h0);
        raw(1'b0, 4'd0);
        check("tmo_lost_pulse", 16'(lock_lost), 16'h0);

        // Out-of-range offsets are not commas.
        repeat (3) raw(1'b1, 4'd12);
        check("oor_locked", 16'(locked), 16'h0);
        check("oor_valid", 16'(symbol_valid), 16'h0);
        check("oor_offset", 16'(lock_offset), 16'h0);
        check("oor_lost", 16'(lock_lost), 16'h0);
        repeat (3) raw(1'b1, 4'd5);
        check("post_oor_locked", 16'(locked), 16'h1);
        check("post_oor_offset", 16'(lock_offset), 16'h5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
